// File: rtl/rect_fill_engine_if.sv
// Write-beat bus from the fill engine toward the display-RAM arbiter.
// Valid/ready handshake carrying one (x, y, data) cell write per accepted beat.
interface rect_fill_engine_if #(
    parameter int unsigned XW = 7,
    parameter int unsigned YW = 5,
    parameter int unsigned DW = 8
);
    logic          wr_valid;
    logic          wr_ready;
    logic [XW-1:0] wr_x;
    logic [YW-1:0] wr_y;
    logic [DW-1:0] wr_data;

    modport master (output wr_valid, wr_x, wr_y, wr_data, input wr_ready);
    modport slave  (input wr_valid, wr_x, wr_y, wr_data, output wr_ready);
endinterface

// File: rtl/rect_fill_engine.sv
// Raster-order rectangle fill of the character buffer: one cell write per accepted beat,
// with region bounds, programmable fill value, backpressure, abort, done and error pulses.
module rect_fill_engine #(
    parameter int unsigned COLS = 80,
    parameter int unsigned ROWS = 30,
    parameter int unsigned XW   = 7,
    parameter int unsigned YW   = 5,
    parameter int unsigned DW   = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 full_screen,
    input  logic [XW-1:0]        x0,
    input  logic [YW-1:0]        y0,
    input  logic [XW-1:0]        x1,
    input  logic [YW-1:0]        y1,
    input  logic [DW-1:0]        fill_data,
    input  logic                 abort,
    rect_fill_engine_if.master   wr,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam logic [XW:0]   ColsLim = (XW+1)'(COLS);
    localparam logic [YW:0]   RowsLim = (YW+1)'(ROWS);
    localparam logic [XW-1:0] XMax    = XW'(COLS - 1);
    localparam logic [YW-1:0] YMax    = YW'(ROWS - 1);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e        state_q;
    logic [XW-1:0] x0_q, x1_q, x_q;
    logic [YW-1:0] y1_q, y_q;
    logic [DW-1:0] data_q;
    logic          valid_q;

    logic [XW-1:0] res_x0, res_x1;
    logic [YW-1:0] res_y0, res_y1;
    logic          cmd_ok;

    // Resolve the command's bounds before validating them.
    always_comb begin
        res_x0 = x0;
        res_y0 = y0;
        res_x1 = x1;
        res_y1 = y1;
        if (full_screen) begin
            res_x0 = '0;
            res_y0 = '0;
            res_x1 = XMax;
            res_y1 = YMax;
        end
        cmd_ok = (res_x0 <= res_x1) && (res_y0 <= res_y1) &&
                 ({1'b0, res_x1} < ColsLim) && ({1'b0, res_y1} < RowsLim);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            x0_q    <= '0;
            x1_q    <= '0;
            y1_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        if (cmd_ok) begin
                            x0_q    <= res_x0;
                            x1_q    <= res_x1;
                            y1_q    <= res_y1;
                            x_q     <= res_x0;
                            y_q     <= res_y0;
                            data_q  <= fill_data;
                            valid_q <= 1'b1;
                            busy    <= 1'b1;
                            state_q <= StRun;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                StRun: begin
                    // Abort wins over completion, so no done pulse even on the final beat.
                    if (abort) begin
                        state_q <= StIdle;
                        valid_q <= 1'b0;
                        busy    <= 1'b0;
                        x_q     <= '0;
                        y_q     <= '0;
                    end else if (wr.wr_ready) begin
                        if (x_q != x1_q) begin
                            x_q <= x_q + 1'b1;
                        end else if (y_q != y1_q) begin
                            x_q <= x0_q;
                            y_q <= y_q + 1'b1;
                        end else begin
                            state_q <= StIdle;
                            valid_q <= 1'b0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            x_q     <= '0;
                            y_q     <= '0;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign wr.wr_valid = valid_q;
    assign wr.wr_x     = x_q;
    assign wr.wr_y     = y_q;
    assign wr.wr_data  = data_q;

endmodule

// File: tb/tb_rect_fill_engine.sv
// Randomised self-checking bench for rect_fill_engine; expected beat streams come from a
// nested-loop raster model of the requested rectangle.
module tb_rect_fill_engine;

    localparam int COLS = 80;
    localparam int ROWS = 30;

    typedef struct packed {
        logic [6:0] x;
        logic [4:0] y;
        logic [7:0] d;
    } beat_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       full_screen = 1'b0;
    logic [6:0] x0 = '0, x1 = '0;
    logic [4:0] y0 = '0, y1 = '0;
    logic [7:0] fill_data = '0;
    logic       abort = 1'b0;
    logic       busy, done, err;

    rect_fill_engine_if #(.XW(7), .YW(5), .DW(8)) bus ();

    rect_fill_engine #(.COLS(COLS), .ROWS(ROWS), .XW(7), .YW(5), .DW(8)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .full_screen (full_screen),
        .x0          (x0),
        .y0          (y0),
        .x1          (x1),
        .y1          (y1),
        .fill_data   (fill_data),
        .abort       (abort),
        .wr          (bus.master),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    int    errors = 0;
    int    checks = 0;
    beat_t exp_q[$];
    beat_t got[$];
    int    ready_pat[$];
    int    done_cnt, done_cycle, last_acc_cycle, busy_cycles, hold_err, mid_start_cycle;
    bit    timed_out;

    // Reference: every cell of the inclusive rectangle, row by row, left to right.
    function automatic void build_model(input int ax0, input int ay0, input int ax1,
                                        input int ay1, input logic [7:0] d);
        beat_t b;
        exp_q.delete();
        for (int y = ay0; y <= ay1; y++) begin
            for (int x = ax0; x <= ax1; x++) begin
                b.x = 7'(x);
                b.y = 5'(y);
                b.d = d;
                exp_q.push_back(b);
            end
        end
    endfunction

    task automatic issue_start(input bit fs, input int ax0, input int ay0, input int ax1,
                               input int ay1, input logic [7:0] d);
        full_screen = fs;
        x0 = 7'(ax0);
        y0 = 5'(ay0);
        x1 = 7'(ax1);
        y1 = 5'(ay1);
        fill_data = d;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Drives wr_ready/abort after a start and records accepted beats until the fill stops.
    task automatic collect(input int prob, input int abort_at, input int max_cyc);
        int    cyc = 0;
        int    tail = -1;
        bit    pv = 0, pr = 0, r;
        beat_t pb, cur;
        got.delete();
        done_cnt = 0; done_cycle = -1; last_acc_cycle = -1;
        busy_cycles = 0; hold_err = 0; timed_out = 0;
        while (1) begin
            if (cyc >= max_cyc) begin
                timed_out = 1;
                break;
            end
            cur.x = bus.wr_x;
            cur.y = bus.wr_y;
            cur.d = bus.wr_data;
            if (pv && !pr && bus.wr_valid && cur !== pb) hold_err++;
            if (done) begin
                done_cnt++;
                done_cycle = cyc;
            end
            if (busy) busy_cycles++;
            if (tail < 0 && !bus.wr_valid) tail = 3;
            if (tail == 0) break;
            if (tail > 0) tail--;
            start = (cyc == mid_start_cycle);
            if (ready_pat.size() > 0) r = ready_pat.pop_front() != 0;
            else r = ($urandom_range(99) < prob);
            bus.wr_ready = r;
            abort = 1'b0;
            if (bus.wr_valid && r) begin
                got.push_back(cur);
                last_acc_cycle = cyc;
                if (got.size() == abort_at) abort = 1'b1;
            end
            pv = bus.wr_valid;
            pr = r;
            pb = cur;
            @(posedge clk);
            #1;
            cyc++;
        end
        start = 1'b0;
        abort = 1'b0;
        bus.wr_ready = 1'b0;
        mid_start_cycle = -1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        bus.wr_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.wr_valid, busy, done, err} !== 4'b0) begin
            errors++;
            $display("FAIL reset_ctrl got=%b want=0000", {bus.wr_valid, busy, done, err});
        end
        checks++;
        if ({bus.wr_x, bus.wr_y, bus.wr_data} !== 20'h0) begin
            errors++;
            $display("FAIL reset_bus got=%h want=0", {bus.wr_x, bus.wr_y, bus.wr_data});
        end
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({bus.wr_valid, busy, done, err} !== 4'b0) begin
            errors++;
            $display("FAIL reset_release got=%b want=0000", {bus.wr_valid, busy, done, err});
        end
    endtask

    task automatic test_full_screen;
        build_model(0, 0, COLS - 1, ROWS - 1, 8'h20);
        issue_start(1'b1, 3, 3, 1, 1, 8'h20);
        collect(100, -1, 3000);
        checks++;
        if (got.size() != exp_q.size() || timed_out) begin
            errors++;
            $display("FAIL full_count got=%0d want=%0d to=%0d", got.size(), exp_q.size(), timed_out);
        end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL full_beat%0d got=%h want=%h", i, got[i], exp_q[i]);
            end
        end
        checks++;
        if (done_cnt != 1 || done_cycle != last_acc_cycle + 1) begin
            errors++;
            $display("FAIL full_done got=%0d@%0d want=1@%0d", done_cnt, done_cycle,
                     last_acc_cycle + 1);
        end
        checks++;
        if (busy_cycles != 2400) begin
            errors++;
            $display("FAIL full_busy got=%0d want=2400", busy_cycles);
        end
    endtask

    task automatic test_region(input int ax0, input int ay0, input int ax1, input int ay1,
                               input logic [7:0] d, input int prob);
        build_model(ax0, ay0, ax1, ay1, d);
        issue_start(1'b0, ax0, ay0, ax1, ay1, d);
        collect(prob, -1, 2000);
        checks++;
        if (got.size() != exp_q.size() || timed_out) begin
            errors++;
            $display("FAIL region_count got=%0d want=%0d", got.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL region_beat%0d got=%h want=%h", i, got[i], exp_q[i]);
            end
        end
        checks++;
        if (done_cnt != 1 || done_cycle != last_acc_cycle + 1 || hold_err != 0) begin
            errors++;
            $display("FAIL region_done got=%0d@%0d hold=%0d want=1@%0d hold=0", done_cnt,
                     done_cycle, hold_err, last_acc_cycle + 1);
        end
    endtask

    task automatic test_backpressure;
        ready_pat = '{0, 0, 1, 0, 1};
        test_region(0, 0, 1, 0, 8'h5C, 100);
    endtask

    task automatic test_random_regions;
        for (int n = 0; n < 6; n++) begin
            int ax0 = $urandom_range(COLS - 1);
            int ay0 = $urandom_range(ROWS - 1);
            int ax1 = $urandom_range(ax0 + 5 > COLS - 1 ? COLS - 1 : ax0 + 5, ax0);
            int ay1 = $urandom_range(ay0 + 3 > ROWS - 1 ? ROWS - 1 : ay0 + 3, ay0);
            test_region(ax0, ay0, ax1, ay1, 8'($urandom), 60);
        end
    endtask

    task automatic test_invalid;
        int bad[4][4] = '{'{5, 0, 4, 0}, '{0, 0, 80, 0}, '{0, 0, 3, 30}, '{0, 7, 3, 6}};
        for (int n = 0; n < 4; n++) begin
            issue_start(1'b0, bad[n][0], bad[n][1], bad[n][2], bad[n][3], 8'h11);
            checks++;
            if ({err, busy, bus.wr_valid} !== 3'b100) begin
                errors++;
                $display("FAIL invalid%0d_pulse got=%b want=100", n, {err, busy, bus.wr_valid});
            end
            @(posedge clk);
            #1;
            checks++;
            if ({err, busy, bus.wr_valid} !== 3'b000) begin
                errors++;
                $display("FAIL invalid%0d_after got=%b want=000", n, {err, busy, bus.wr_valid});
            end
        end
    endtask

    task automatic test_start_while_busy;
        build_model(2, 1, 5, 2, 8'h3E);
        issue_start(1'b0, 2, 1, 5, 2, 8'h3E);
        full_screen = 1'b1;
        fill_data = 8'hF0;
        mid_start_cycle = 2;
        collect(100, -1, 200);
        checks++;
        if (got != exp_q || done_cnt != 1) begin
            errors++;
            $display("FAIL busy_start got=%0d beats done=%0d want=%0d beats done=1",
                     got.size(), done_cnt, exp_q.size());
        end
    endtask

    task automatic test_abort(input int at);
        build_model(0, 0, COLS - 1, ROWS - 1, 8'h77);
        issue_start(1'b1, 0, 0, 0, 0, 8'h77);
        collect(100, at, 3000);
        checks++;
        if (got.size() != at || done_cnt != 0 || timed_out) begin
            errors++;
            $display("FAIL abort%0d got=%0d beats done=%0d want=%0d beats done=0", at,
                     got.size(), done_cnt, at);
        end
        checks++;
        if (got.size() > 0 && got[got.size() - 1] !== exp_q[at - 1]) begin
            errors++;
            $display("FAIL abort%0d_last got=%h want=%h", at, got[got.size() - 1], exp_q[at - 1]);
        end
    endtask

    task automatic test_reset_mid;
        int acc = 0;
        int guard = 0;
        issue_start(1'b1, 0, 0, 0, 0, 8'h42);
        bus.wr_ready = 1'b1;
        while (acc < 50 && guard < 200) begin
            if (bus.wr_valid) acc++;
            @(posedge clk);
            #1;
            guard++;
        end
        checks++;
        if (acc != 50) begin
            errors++;
            $display("FAIL rstmid_reach got=%0d want=50", acc);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({bus.wr_valid, busy, done, err, bus.wr_x, bus.wr_y, bus.wr_data} !== 24'h0) begin
            errors++;
            $display("FAIL rstmid_async got=%h want=0",
                     {bus.wr_valid, busy, done, err, bus.wr_x, bus.wr_y, bus.wr_data});
        end
        bus.wr_ready = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({done, err, busy} !== 3'b000) begin
            errors++;
            $display("FAIL rstmid_nopulse got=%b want=000", {done, err, busy});
        end
        test_region(0, 0, 0, 0, 8'h01, 100);
    endtask

    initial begin
        mid_start_cycle = -1;
        test_reset();
        test_full_screen();
        test_region(10, 5, 12, 6, 8'hAA, 100);
        test_backpressure();
        test_random_regions();
        test_invalid();
        test_start_while_busy();
        test_abort(100);
        test_abort(2400);
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rect_fill_engine.md
Name: rect_fill_engine

Overview:
- Parametrised successor of the screen-clear sequencer in the display datapath.
- Sweeps a rectangular region (or the full screen) of the character buffer in raster order, row by row, left to right.
- Emits one write (x, y, data) per accepted beat over a valid/ready handshake toward the display-RAM arbiter.
- Adds region bounds, a programmable fill value, backpressure, abort, a done pulse and an error pulse.

Parameters:
- COLS, 80, screen width in character cells.
- ROWS, 30, screen height in character cells.
- XW, 7, x coordinate width; must satisfy 2^XW >= COLS.
- YW, 5, y coordinate width; must satisfy 2^YW >= ROWS.
- DW, 8, fill data width (character code or attribute).

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset, asynchronous, active-low.
- start  in  1  single-cycle command strobe; sampled only in IDLE.
- full_screen  in  1  sampled with start; 1 = region is 0..COLS-1 x 0..ROWS-1, and x0/y0/x1/y1 are ignored.
- x0  in  XW  region left column, inclusive.
- y0  in  YW  region top row, inclusive.
- x1  in  XW  region right column, inclusive.
- y1  in  YW  region bottom row, inclusive.
- fill_data  in  DW  value written to every cell; latched at start.
- abort  in  1  stop the fill immediately.
- wr_valid  out  1  write beat valid.
- wr_ready  in  1  downstream accepts the beat.
- wr_x  out  XW  write column.
- wr_y  out  YW  write row.
- wr_data  out  DW  write data.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse after the last beat is accepted.
- err  out  1  one-cycle pulse on a rejected command.

Behaviour:
- Reset values: all outputs 0; state IDLE; internal coordinate, bound and data registers 0.
- All outputs are registered and driven directly from flops.
- States: IDLE, RUN.

IDLE:
- start=1 latches the command. Bounds are (x0,y0,x1,y1) from the ports, or (0,0,COLS-1,ROWS-1) when full_screen=1. fill_data is latched.
- Validity check on the resolved bounds: x0<=x1, y0<=y1, x1<COLS, y1<ROWS.
- Invalid command: err=1 for the next cycle; state stays IDLE; no beats issued.
- Valid command: next cycle state=RUN, busy=1, wr_valid=1, wr_x=x0, wr_y=y0, wr_data=latched fill value. Latency is 1 cycle from start to the first beat.
- abort has no effect in IDLE.

RUN:
- wr_valid stays 1 continuously; wr_x, wr_y and wr_data hold while wr_ready=0.
- Beat accepted when wr_valid&wr_ready. On acceptance:
  - wr_x<x1: wr_x+1.
  - wr_x==x1 and wr_y<y1: wr_x=x0, wr_y+1.
  - wr_x==x1 and wr_y==y1: next cycle state=IDLE, wr_valid=0, busy=0, done=1 for exactly one cycle; wr_x and wr_y reset to 0.
- Throughput: 1 beat per cycle with wr_ready held high. Total beats = (x1-x0+1)*(y1-y0+1).
- start is ignored while in RUN; the command is not queued.

Abort:
- abort=1 in RUN: next cycle state=IDLE, wr_valid=0, busy=0; no done pulse.
- A beat accepted in the same cycle as abort counts as written; no further beats follow.
- abort takes priority over last-beat completion: abort coincident with the final accept gives no done pulse.

Coordinate arithmetic:
- Unsigned; increments never exceed the latched bounds, so no wrap-around is possible.
- Single-cell region (x0==x1, y0==y1): exactly one beat, then done.

Reset:
- Asserting reset_n mid-operation returns to IDLE with all outputs 0 asynchronously; no done or err pulse follows.

Test Plan:
- Full screen, wr_ready=1, start with full_screen=1, fill_data=0x20 -> 2400 beats. First beat (0,0) one cycle after start; beat 80 is (0,1); last beat (79,29); done pulses the cycle after the last beat; busy high for exactly 2400 cycles.
- Region x0=10,y0=5,x1=12,y1=6, fill=0xAA -> beats (10,5),(11,5),(12,5),(10,6),(11,6),(12,6), all with data 0xAA, then a single done pulse.
- Backpressure: region 0,0..1,0 with wr_ready toggling 0,0,1,0,1 -> wr_x/wr_y/wr_data hold while ready=0; exactly 2 beats accepted ((0,0),(1,0)); done pulses after the second accept.
- Invalid commands: x0=5,x1=4 -> err pulse, busy stays 0, no wr_valid. x1=80 with COLS=80 -> err pulse. start while busy -> ignored, current fill continues unchanged.
- Abort: full-screen fill, abort asserted on the 100th accepted beat -> wr_valid=0 the next cycle, 100 beats total, no done pulse. Repeat with abort on the final beat (79,29) -> 2400 beats, no done.
- Reset mid-fill: reset_n low at beat 50 -> all outputs 0 immediately. After release, a new start with region 0,0..0,0 -> one beat (0,0), then done.
